// File: rtl/bmem_arb_pkg.sv
// bmem_arb_pkg: shared types and line/beat geometry for the burst-memory arbiter
package bmem_arb_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} arb_state_t;
    typedef enum logic {REQ_I, REQ_D} req_id_t;
endpackage

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: beat counter, line assembly and write-beat selection for one burst
module cacheline_adapter
    import bmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              reading,
    input  logic              writing,
    input  logic              clear,
    input  logic [LINE_W-1:0] wline,
    input  logic              bmem_resp,
    input  logic [BEAT_W-1:0] bmem_rdata,
    output logic [BEAT_W-1:0] wbeat,
    output logic [LINE_W-1:0] line_fill,
    output logic              done
);
    logic [1:0] beat_cnt, cnt_nx;
    logic [BEATS-1:0][BEAT_W-1:0] line_q, fill;
    logic ack;

    assign ack       = (reading || writing) && bmem_resp;
    assign done      = ack && beat_cnt == 2'(BEATS - 1);
    assign cnt_nx    = beat_cnt + 2'd1;
    assign line_fill = fill;

    // Buffered line with the beat arriving this cycle dropped into its slot
    always_comb begin
        fill = line_q;
        fill[beat_cnt] = bmem_rdata;
    end

    // Beat counter (cleared only from DONE), line buffer and registered write beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            line_q   <= '0;
            wbeat    <= '0;
        end else begin
            beat_cnt <= clear ? 2'd0 : (ack && !done) ? cnt_nx : beat_cnt;
            line_q   <= start ? wline : (reading && bmem_resp) ? fill : line_q;
            wbeat    <= start ? wline[BEAT_W-1:0] : (writing && bmem_resp && !done) ? line_q[cnt_nx] : wbeat;
        end
    end
endmodule

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: round-robin sharing of the burst-memory port between I-cache and D-cache
module bmem_arbiter
    import bmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);
    arb_state_t state, state_nx;
    req_id_t last_grant, grant;
    logic d_req, pick_d, go, go_wr, done;
    logic [LINE_W-1:0] line_fill;

    assign d_req  = d_read || d_write;
    assign pick_d = d_req && (!i_read || last_grant == REQ_I);
    assign go     = state == IDLE && (i_read || d_req);
    assign go_wr  = go && pick_d && d_write;

    cacheline_adapter u_adapter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (go),
        .reading    (state == READ),
        .writing    (state == WRITE),
        .clear      (state == DONE),
        .wline      (d_wdata),
        .bmem_resp  (bmem_resp),
        .bmem_rdata (bmem_rdata),
        .wbeat      (bmem_wdata),
        .line_fill  (line_fill),
        .done       (done)
    );

    // Next state: grant from IDLE, leave the burst on its last beat, one cycle in DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        state_nx = go_wr ? WRITE : go ? READ : IDLE;
            READ, WRITE: state_nx = done ? DONE : state;
            default:     state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Registered outputs, grant bookkeeping and returned lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant        <= REQ_I;
            last_grant   <= REQ_I;
            bmem_address <= '0;
            bmem_read    <= 1'b0;
            bmem_write   <= 1'b0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            if (go) begin
                grant        <= pick_d ? REQ_D : REQ_I;
                bmem_address <= (pick_d ? d_addr : i_addr) & ~32'h1F;
            end
            bmem_read  <= (go && !go_wr) || (state == READ && bmem_read && !bmem_resp);
            bmem_write <= go_wr || (state == WRITE && !done);
            i_resp     <= done && grant == REQ_I;
            d_resp     <= done && grant == REQ_D;
            if (done && state == READ && grant == REQ_I) i_rdata <= line_fill;
            if (done && state == READ && grant == REQ_D) d_rdata <= line_fill;
            if (state == DONE) last_grant <= grant;
        end
    end
endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: randomized bench with a burst-memory model and a line-level reference
module tb_bmem_arbiter;
    import bmem_arb_pkg::*;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [31:0] i_addr = '0, d_addr = '0, bmem_address;
    logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [LINE_W-1:0] d_wdata = '0, i_rdata, d_rdata;
    logic i_resp, d_resp, bmem_read, bmem_write, bmem_resp = 1'b0;
    logic [BEAT_W-1:0] bmem_wdata, bmem_rdata = '0;

    always #5 clk = ~clk;

    bmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
    );

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory model state
    bit busy = 0, is_wr = 0, wr_end_chk = 0, stray = 0;
    logic [31:0] m_addr;
    int m_beat, m_wait, beats_done = 0, gap_lo = 0, gap_hi = 2, lat_hi = 3;
    logic [LINE_W-1:0] m_wline, rd_line;
    logic [LINE_W-1:0] wmem [logic [31:0]];
    logic [31:0] addr_q[$];
    bit wr_q[$];
    int last_win = 0;

    function automatic logic [LINE_W-1:0] pattern(input logic [31:0] a);
        logic [LINE_W-1:0] p;
        for (int b = 0; b < BEATS; b++) p[b*BEAT_W +: BEAT_W] = {a, 8'(b), 24'h5A5A5A};
        return p;
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
        return wmem.exists(a) ? wmem[a] : pattern(a);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // burst memory: random latency and inter-beat gaps, reset alongside the DUT
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bmem_resp = 1'b0;
            if (!rst_n) begin
                busy = 0;
                wr_end_chk = 0;
            end else begin
                if (wr_end_chk) begin
                    check("wr_drop", bmem_write, 0);
                    wr_end_chk = 0;
                end
                if (!busy && (bmem_read || bmem_write)) begin
                    check("no_overlap", bmem_read && bmem_write, 0);
                    busy = 1;
                    is_wr = bmem_write;
                    m_addr = bmem_address;
                    m_beat = 0;
                    beats_done = 0;
                    m_wait = $urandom_range(0, lat_hi);
                    addr_q.push_back(bmem_address);
                    wr_q.push_back(bmem_write);
                end
                if (busy) begin
                    if (m_wait > 0) m_wait--;
                    else begin
                        bmem_resp = 1'b1;
                        if (is_wr) begin
                            check("wr_valid", bmem_write, 1);
                            m_wline[m_beat*BEAT_W +: BEAT_W] = bmem_wdata;
                        end else begin
                            rd_line = mem_line(m_addr);
                            bmem_rdata = rd_line[m_beat*BEAT_W +: BEAT_W];
                        end
                        m_beat++;
                        beats_done = m_beat;
                        if (m_beat == BEATS) begin
                            busy = 0;
                            if (is_wr) begin
                                wmem[m_addr] = m_wline;
                                wr_end_chk = 1;
                            end
                        end
                        m_wait = $urandom_range(gap_lo, gap_hi);
                    end
                end else if (stray) bmem_resp = 1'b1;
            end
        end
    end

    task automatic check_zero(input string p);
        check({p, "_i_rdata"}, i_rdata, 0);
        check({p, "_d_rdata"}, d_rdata, 0);
        check({p, "_i_resp"}, i_resp, 0);
        check({p, "_d_resp"}, d_resp, 0);
        check({p, "_bmem_read"}, bmem_read, 0);
        check({p, "_bmem_write"}, bmem_write, 0);
        check({p, "_bmem_address"}, bmem_address, 0);
        check({p, "_bmem_wdata"}, bmem_wdata, 0);
    endtask

    // one arbitration round: raise requests (D optionally late), collect resps, compare with the model
    task automatic run_round(input bit do_i, input bit do_d, input bit d_wr, input bit d_rd, input int stagger,
                             input logic [31:0] ia, input logic [31:0] da, input logic [LINE_W-1:0] wd);
        logic [LINE_W-1:0] exp_i, exp_d, d_before;
        logic [31:0] exp_a[$];
        bit exp_w[$];
        int ord[$];
        int first, i_cnt, d_cnt, tail;
        bit d_on;
        i_cnt = 0; d_cnt = 0; tail = 0; d_on = 0;
        exp_i = mem_line(ia & ~32'h1F);
        exp_d = mem_line(da & ~32'h1F);
        d_before = d_rdata;
        first = (do_i && do_d) ? ((stagger > 0) ? 0 : 1 - last_win) : (do_d ? 1 : 0);
        if (first == 0) begin
            if (do_i) begin exp_a.push_back(ia & ~32'h1F); exp_w.push_back(0); end
            if (do_d) begin exp_a.push_back(da & ~32'h1F); exp_w.push_back(d_wr); end
        end else begin
            if (do_d) begin exp_a.push_back(da & ~32'h1F); exp_w.push_back(d_wr); end
            if (do_i) begin exp_a.push_back(ia & ~32'h1F); exp_w.push_back(0); end
        end
        addr_q.delete();
        wr_q.delete();
        @(negedge clk);
        i_addr = ia;
        i_read = do_i;
        d_addr = da;
        d_wdata = wd;
        for (int c = 0; c < 1000 && tail < 3; c++) begin
            if (do_d && !d_on && c >= stagger) begin
                d_read = d_rd;
                d_write = d_wr;
                d_on = 1;
            end
            @(negedge clk);
            if (i_resp) begin i_cnt++; ord.push_back(0); i_read = 0; end
            if (d_resp) begin d_cnt++; ord.push_back(1); d_read = 0; d_write = 0; end
            if (i_cnt >= int'(do_i) && d_cnt >= int'(do_d) && d_on == do_d) tail++;
        end
        i_read = 0; d_read = 0; d_write = 0;
        check("done_in_time", tail >= 3, 1);
        check("i_resp_cnt", i_cnt, do_i);
        check("d_resp_cnt", d_cnt, do_d);
        check("bursts", addr_q.size(), exp_a.size());
        for (int k = 0; k < exp_a.size() && k < addr_q.size(); k++) begin
            check("burst_addr", addr_q[k], exp_a[k]);
            check("burst_wr", wr_q[k], exp_w[k]);
        end
        if (ord.size() > 0) check("first_resp", ord[0], first);
        if (do_i) check("i_rdata", i_rdata, exp_i);
        if (do_d && d_wr) begin
            check("d_wline", mem_line(da & ~32'h1F), wd);
            check("d_rdata_kept", d_rdata, d_before);
        end else if (do_d) check("d_rdata", d_rdata, exp_d);
        last_win = (do_i && do_d) ? 1 - first : first;
    endtask

    function automatic logic [31:0] rand_ia();
        return 32'h6000_0000 | ($urandom() & 32'h00FF_FFFF);
    endfunction

    function automatic logic [31:0] rand_da();
        return 32'h8000_0000 + 32'($urandom_range(0, 7) << 5) + 32'($urandom_range(0, 31));
    endfunction

    initial begin
        logic [LINE_W-1:0] tp_line, wr_line;
        bit di, dd, dw, dr;
        tp_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        wr_line = {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}};
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        last_win = 0;

        // simultaneous reads twice: D, I, then D again
        run_round(1, 1, 0, 1, 0, rand_ia(), rand_da(), rand_line());
        run_round(1, 1, 0, 1, 0, rand_ia(), rand_da(), rand_line());

        // directed I read with a known line
        wmem[32'h6000_0000] = tp_line;
        run_round(1, 0, 0, 0, 0, 32'h6000_0014, 32'h8000_0000, '0);
        check("tp_i_line", i_rdata, tp_line);

        // D writeback with 2-cycle gaps between acks
        gap_lo = 2; gap_hi = 2;
        run_round(0, 1, 1, 0, 0, 32'h6000_0000, 32'h8000_0040, wr_line);
        gap_lo = 0; gap_hi = 2;

        // read and write together: write wins
        run_round(0, 1, 1, 1, 0, rand_ia(), 32'h8000_0060, rand_line());

        // reset after two read beats
        @(negedge clk);
        beats_done = 0;
        i_addr = 32'h6000_1000;
        i_read = 1'b1;
        for (int c = 0; c < 200 && beats_done < 2; c++) @(negedge clk);
        check("two_beats_seen", beats_done >= 2, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        bmem_resp = 1'b0;
        #1 check_zero("midrst");
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_hold_i_resp", i_resp, 0);
        rst_n = 1'b1;
        last_win = 0;
        run_round(1, 0, 0, 0, 0, rand_ia(), rand_da(), '0);

        // stray acknowledge while idle
        @(negedge clk);
        stray = 1;
        repeat (3) begin
            @(negedge clk);
            check("stray_i_resp", i_resp, 0);
            check("stray_d_resp", d_resp, 0);
            check("stray_bmem_req", bmem_read || bmem_write, 0);
        end
        stray = 0;
        run_round(1, 1, 0, 1, 0, rand_ia(), rand_da(), rand_line());

        // random rounds
        for (int r = 0; r < 40; r++) begin
            di = 1'($urandom_range(0, 1));
            dd = di ? 1'($urandom_range(0, 1)) : 1'b1;
            dw = 1'($urandom_range(0, 1));
            dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
            run_round(di, dd, dw, dr, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                      rand_ia(), rand_da(), rand_line());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
